ball_motion: RTL
================

Name: ball_motion

Overview:
- Per-ball kinematics engine; one instance per ball (white, red).
- Consumes the collision-response velocities, collision flag and hole-hit flag produced by the collision/hit logic, plus cue shots.
- Integrates fixed-point position once per frame, applies friction and stop detection, and handles pocketing and respawn.
- Drives the ball's top-left position and current velocity back to the drawing and collision logic.

Parameters:
INIT_X, 320, respawn/reset top-left X in pixels
INIT_Y, 240, respawn/reset top-left Y in pixels
FRAC, 4, fractional bits of position and velocity (velocity unit = 1/16 px per frame)
FRICTION_SHIFT, 5, proportional friction divisor exponent
STOP_THRESHOLD, 4, a velocity component with magnitude below this, after friction, becomes 0
MAX_VEL, 511, velocity saturation magnitude
MAX_X, 607, largest legal top-left X in pixels
MAX_Y, 447, largest legal top-left Y in pixels

Ports:
clk  in  1  system clock
resetN  in  1  synchronous, active-high reset (the name is kept for codebase consistency; asserted = 1)
startOfFrame  in  1  one-cycle pulse; update strobe
shotValid  in  1  cue shot request
shotVelX, shotVelY  in  11 signed  shot velocity
collisionOccurred  in  1  collision flag from the hit logic
velXIn, velYIn  in  11 signed  collision-response velocity
holeHit  in  1  ball entered a pocket
respawn  in  1  one-cycle pulse; return a sunk ball to the table
topLeftPosX, topLeftPosY  out  11  integer pixel position (internal position >> FRAC)
velX, velY  out  11 signed  current velocity
moving  out  1  1 when state is MOVING
inHole  out  1  1 when state is SUNK

Behaviour:
- Reset (resetN=1 at a clk edge):
  - Position = INIT_X/INIT_Y with fraction 0; velocity 0.
  - state = IDLE; pending collision and pending shot flags cleared.
  - Outputs: topLeftPosX=INIT_X, topLeftPosY=INIT_Y, velX=velY=0, moving=0, inHole=0.
  - Reset wins over every other input, including mid-motion and in SUNK.
- Internal position: 15-bit unsigned fixed point per axis (11 integer + FRAC fraction).
- State IDLE:
  - shotValid latches shotVel into a pending-shot register; last shot wins.
  - At startOfFrame with a pending shot: apply the update step using the shot velocity, then state = MOVING.
- State MOVING:
  - On the first collisionOccurred since the last startOfFrame, latch velXIn/velYIn into pending. Later pulses in the same frame are ignored.
  - A collision coincident with startOfFrame is latched for the next frame.
  - At startOfFrame: v = pending ? latched : current velocity; clear pending; apply the update step.
  - shotValid is ignored in MOVING.
- Update step, per axis, one cycle (results visible the cycle after startOfFrame):
  - Saturate v to ±MAX_VEL.
  - p_next = p + v, sign-extended. If p_next < 0, set 0. If p_next > MAX<<FRAC, set MAX<<FRAC. Velocity is not reflected here.
  - v_next = v − (v >>> FRICTION_SHIFT) − sgn(v).
  - If |v_next| < STOP_THRESHOLD, v_next = 0.
  - If both v_next components are 0, state = IDLE.
- holeHit, in IDLE or MOVING:
  - Next cycle: state = SUNK, velocity 0, all pending flags cleared.
  - Priority is higher than a coincident startOfFrame, collision or shot.
- State SUNK:
  - Position frozen; all inputs except respawn and reset are ignored.
  - respawn: next cycle, position = INIT, velocity 0, state = IDLE.
- respawn outside SUNK is ignored.
- Outputs are registered.

Decomposition:
- Shared package billiard_pkg holds:
  - ball_state_t enum {IDLE, MOVING, SUNK};
  - FRAC and FRICTION_SHIFT defaults;
  - the table limit constants.
- One sub-module, velocity_decay: combinational per-axis saturate + friction + stop-threshold. Instantiate it twice.

Test Plan:
1. Reset, then idle for 3 frames -> pos (320,240), vel (0,0), moving=0, inHole=0.
2. shotValid with shotVel (64,0), then startOfFrame -> next cycle topLeftPosX=324, velX=61, moving=1.
3. In MOVING, two collision pulses in one frame, velXIn=−62 then velXIn=100 -> at next startOfFrame velX becomes −59 (first pulse used), and X moves by −62/16 px.
4. velX=5, velY=0, MOVING: startOfFrame -> velX=4, still MOVING; next startOfFrame -> velX=0, moving=0.
5. posX=2 px, velX=−64: startOfFrame -> topLeftPosX=0, velX=−61 (clamp only, no reflection).
6. holeHit coincident with startOfFrame while moving -> inHole=1, vel 0, position unchanged. Then respawn -> pos (320,240), inHole=0. Then assert resetN mid-motion -> all reset values next cycle.

Source files
------------

// File: rtl/billiard_pkg.sv
// ============================================================================
// billiard_pkg : shared ball state encoding, fixed-point defaults, table limits
// Rev 1.0
// ============================================================================
`default_nettype none

package billiard_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVING = 2'd1,
    SUNK   = 2'd2
  } ball_state_t;

  localparam int DEF_FRAC           = 4;
  localparam int DEF_FRICTION_SHIFT = 5;
  localparam int DEF_STOP_THRESHOLD = 4;
  localparam int DEF_MAX_VEL        = 511;
  localparam int TABLE_MAX_X        = 607;
  localparam int TABLE_MAX_Y        = 447;
  localparam int PIX_W              = 11;
  localparam int VEL_W              = 11;

endpackage

`default_nettype wire

// File: rtl/velocity_decay.sv
// ============================================================================
// velocity_decay : one-axis saturate, proportional friction and stop snap
// Rev 1.0
// ============================================================================
`default_nettype none

module velocity_decay #(
  parameter int W              = 11,
  parameter int FRICTION_SHIFT = 5,
  parameter int STOP_THRESHOLD = 4,
  parameter int MAX_VEL        = 511
) (
  input  logic signed [W-1:0] v_i,
  output logic signed [W-1:0] v_sat_o,
  output logic signed [W-1:0] v_next_o
);

  localparam logic signed [W-1:0] c_max  = W'(MAX_VEL);
  localparam logic signed [W-1:0] c_min  = -c_max;
  localparam logic signed [W-1:0] c_stop = W'(STOP_THRESHOLD);

  logic signed [W-1:0] w_sgn;
  logic signed [W-1:0] w_dec;
  logic signed [W-1:0] w_abs;

  always_comb begin
    if (v_i > c_max)      v_sat_o = c_max;
    else if (v_i < c_min) v_sat_o = c_min;
    else                  v_sat_o = v_i;
  end

  // The extra -sgn term guarantees small velocities still decay to zero.
  assign w_sgn    = (v_sat_o > 0) ? W'(1) : ((v_sat_o < 0) ? -W'(1) : '0);
  assign w_dec    = v_sat_o - (v_sat_o >>> FRICTION_SHIFT) - w_sgn;
  assign w_abs    = (w_dec < 0) ? -w_dec : w_dec;
  assign v_next_o = (w_abs < c_stop) ? '0 : w_dec;

endmodule

`default_nettype wire

// File: rtl/ball_motion.sv
// ============================================================================
// ball_motion : per-ball fixed-point kinematics with shots, collisions, pockets
// Rev 1.0
// ============================================================================
`default_nettype none

module ball_motion
  import billiard_pkg::*;
#(
  parameter int INIT_X         = 320,
  parameter int INIT_Y         = 240,
  parameter int FRAC           = DEF_FRAC,
  parameter int FRICTION_SHIFT = DEF_FRICTION_SHIFT,
  parameter int STOP_THRESHOLD = DEF_STOP_THRESHOLD,
  parameter int MAX_VEL        = DEF_MAX_VEL,
  parameter int MAX_X          = TABLE_MAX_X,
  parameter int MAX_Y          = TABLE_MAX_Y
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    startOfFrame,
  input  logic                    shotValid,
  input  logic signed [VEL_W-1:0] shotVelX,
  input  logic signed [VEL_W-1:0] shotVelY,
  input  logic                    collisionOccurred,
  input  logic signed [VEL_W-1:0] velXIn,
  input  logic signed [VEL_W-1:0] velYIn,
  input  logic                    holeHit,
  input  logic                    respawn,
  output logic [PIX_W-1:0]        topLeftPosX,
  output logic [PIX_W-1:0]        topLeftPosY,
  output logic signed [VEL_W-1:0] velX,
  output logic signed [VEL_W-1:0] velY,
  output logic                    moving,
  output logic                    inHole
);

  localparam int POS_W = PIX_W + FRAC;
  localparam int EXT_W = POS_W + 2;

  localparam logic [POS_W-1:0] c_init_x = POS_W'(INIT_X << FRAC);
  localparam logic [POS_W-1:0] c_init_y = POS_W'(INIT_Y << FRAC);
  localparam logic [POS_W-1:0] c_max_x  = POS_W'(MAX_X << FRAC);
  localparam logic [POS_W-1:0] c_max_y  = POS_W'(MAX_Y << FRAC);

  // Clamp without reflection; bouncing off cushions belongs to the hit logic.
  function automatic logic [POS_W-1:0] step_pos(input logic [POS_W-1:0]        p,
                                                input logic signed [VEL_W-1:0] v,
                                                input logic [POS_W-1:0]        pmax);
    logic signed [EXT_W-1:0] sum;
    sum = $signed({2'b00, p}) + EXT_W'(v);
    if (sum < 0)
      return '0;
    else if (sum > $signed({2'b00, pmax}))
      return pmax;
    else
      return sum[POS_W-1:0];
  endfunction

  ball_state_t             state_q, state_d;
  logic [POS_W-1:0]        pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic signed [VEL_W-1:0] vel_x_q, vel_x_d, vel_y_q, vel_y_d;
  logic                    pend_shot_q, pend_shot_d;
  logic signed [VEL_W-1:0] shot_x_q, shot_x_d, shot_y_q, shot_y_d;
  logic                    pend_col_q, pend_col_d;
  logic signed [VEL_W-1:0] col_x_q, col_x_d, col_y_q, col_y_d;

  logic signed [VEL_W-1:0] w_vsrc_x, w_vsrc_y;
  logic signed [VEL_W-1:0] w_vsat_x, w_vsat_y;
  logic signed [VEL_W-1:0] w_vnxt_x, w_vnxt_y;
  logic [POS_W-1:0]        w_pnxt_x, w_pnxt_y;
  logic                    w_stop;

  assign w_vsrc_x = (state_q == MOVING) ? (pend_col_q ? col_x_q : vel_x_q) : shot_x_q;
  assign w_vsrc_y = (state_q == MOVING) ? (pend_col_q ? col_y_q : vel_y_q) : shot_y_q;

  velocity_decay #(
    .W(VEL_W), .FRICTION_SHIFT(FRICTION_SHIFT),
    .STOP_THRESHOLD(STOP_THRESHOLD), .MAX_VEL(MAX_VEL)
  ) u_decay_x (
    .v_i(w_vsrc_x), .v_sat_o(w_vsat_x), .v_next_o(w_vnxt_x)
  );

  velocity_decay #(
    .W(VEL_W), .FRICTION_SHIFT(FRICTION_SHIFT),
    .STOP_THRESHOLD(STOP_THRESHOLD), .MAX_VEL(MAX_VEL)
  ) u_decay_y (
    .v_i(w_vsrc_y), .v_sat_o(w_vsat_y), .v_next_o(w_vnxt_y)
  );

  assign w_pnxt_x = step_pos(pos_x_q, w_vsat_x, c_max_x);
  assign w_pnxt_y = step_pos(pos_y_q, w_vsat_y, c_max_y);
  assign w_stop   = (w_vnxt_x == '0) && (w_vnxt_y == '0);

  always_comb begin
    state_d     = state_q;
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    vel_x_d     = vel_x_q;
    vel_y_d     = vel_y_q;
    pend_shot_d = pend_shot_q;
    shot_x_d    = shot_x_q;
    shot_y_d    = shot_y_q;
    pend_col_d  = pend_col_q;
    col_x_d     = col_x_q;
    col_y_d     = col_y_q;

    case (state_q)
      IDLE: begin
        if (startOfFrame && pend_shot_q) begin
          pos_x_d     = w_pnxt_x;
          pos_y_d     = w_pnxt_y;
          vel_x_d     = w_vnxt_x;
          vel_y_d     = w_vnxt_y;
          pend_shot_d = 1'b0;
          state_d     = w_stop ? IDLE : MOVING;
        end
        if (shotValid) begin
          pend_shot_d = 1'b1;
          shot_x_d    = shotVelX;
          shot_y_d    = shotVelY;
        end
      end
      MOVING: begin
        if (startOfFrame) begin
          pos_x_d    = w_pnxt_x;
          pos_y_d    = w_pnxt_y;
          vel_x_d    = w_vnxt_x;
          vel_y_d    = w_vnxt_y;
          pend_col_d = 1'b0;
          if (w_stop) state_d = IDLE;
        end
        // A pulse on the frame strobe opens a new frame's latch window.
        if (collisionOccurred && (startOfFrame || !pend_col_q)) begin
          pend_col_d = 1'b1;
          col_x_d    = velXIn;
          col_y_d    = velYIn;
        end
        if (state_d == IDLE) pend_col_d = 1'b0;
      end
      SUNK: begin
        if (respawn) begin
          pos_x_d = c_init_x;
          pos_y_d = c_init_y;
          vel_x_d = '0;
          vel_y_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (holeHit && (state_q != SUNK)) begin
      state_d     = SUNK;
      pos_x_d     = pos_x_q;
      pos_y_d     = pos_y_q;
      vel_x_d     = '0;
      vel_y_d     = '0;
      pend_shot_d = 1'b0;
      pend_col_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (resetN) begin
      state_q     <= IDLE;
      pos_x_q     <= c_init_x;
      pos_y_q     <= c_init_y;
      vel_x_q     <= '0;
      vel_y_q     <= '0;
      pend_shot_q <= 1'b0;
      shot_x_q    <= '0;
      shot_y_q    <= '0;
      pend_col_q  <= 1'b0;
      col_x_q     <= '0;
      col_y_q     <= '0;
    end else begin
      state_q     <= state_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      vel_x_q     <= vel_x_d;
      vel_y_q     <= vel_y_d;
      pend_shot_q <= pend_shot_d;
      shot_x_q    <= shot_x_d;
      shot_y_q    <= shot_y_d;
      pend_col_q  <= pend_col_d;
      col_x_q     <= col_x_d;
      col_y_q     <= col_y_d;
    end
  end

  assign topLeftPosX = pos_x_q[POS_W-1:FRAC];
  assign topLeftPosY = pos_y_q[POS_W-1:FRAC];
  assign velX        = vel_x_q;
  assign velY        = vel_y_q;
  assign moving      = (state_q == MOVING);
  assign inHole      = (state_q == SUNK);

endmodule

`default_nettype wire
